// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared types for the data-memory arbiter.
//   arb_state_t : current owner of the data_mem port (core or host).
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_HOST = 1'b1
  } arb_state_t;

endpackage

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single-ported data_mem between the core load/store path and a
// host port (program loader / debug reader). The core has priority; a
// starvation counter guarantees the host eventually gets in, and a burst
// limit bounds how long the host may hold memory while the core waits.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   core_req/we/addr/wdata: core access request (LD/ST)
//   core_rdata            : combinational pass-through of mem_rdata
//   core_stall            : core denied this cycle (ORed into Halt)
//   host_req/we/addr/wdata: host beat
//   host_gnt              : host beat accepted this cycle
//   host_rdata/rvalid     : registered host read data, one-cycle pulse
//   mem_addr/wdata/we     : to data_mem
//   mem_rdata             : from data_mem (combinational read)
//   state                 : current owner, exposed for observation
//
// Host handshake: host_req is a valid that the host holds, with stable
// address/data, until a cycle in which host_gnt is high; a beat transfers
// exactly in a cycle where host_req and host_gnt are both high. A granted
// read returns its data with host_rvalid one cycle later.
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int STARVE    = 4,
  parameter int BURST_MAX = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic [DW-1:0] core_rdata,
  output logic          core_stall,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output arb_state_t    state
);

  localparam int SW = $clog2(STARVE) + 1;
  localparam int BW = $clog2(BURST_MAX) + 1;
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE - 1);
  localparam logic [BW-1:0] BURST_LAST  = BW'(BURST_MAX - 1);

  arb_state_t      state_next;
  logic [SW-1:0]   starve_cnt;
  logic [BW-1:0]   beat_cnt;

  assign core_rdata = mem_rdata;

  // Next-owner and port muxing. The cycle in which a decision is made is
  // still served by the current owner.
  always_comb begin
    state_next = state;
    mem_addr   = core_addr;
    mem_wdata  = core_wdata;
    mem_we     = core_req & core_we;
    host_gnt   = 1'b0;
    core_stall = 1'b0;
    case (state)
      OWN_CORE: begin
        if (host_req && (!core_req || starve_cnt == STARVE_LAST)) begin
          state_next = OWN_HOST;
        end
      end
      OWN_HOST: begin
        mem_addr   = host_addr;
        mem_wdata  = host_wdata;
        mem_we     = host_req & host_we;
        host_gnt   = host_req;
        core_stall = core_req;
        // Dropping host_req leaves one host-owned bubble before handback.
        if (!host_req || (host_gnt && core_req && beat_cnt == BURST_LAST)) begin
          state_next = OWN_CORE;
        end
      end
      default: state_next = OWN_CORE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= OWN_CORE;
      starve_cnt  <= '0;
      beat_cnt    <= '0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
    end else begin
      state <= state_next;

      if (state == OWN_CORE) begin
        if (state_next == OWN_HOST || !host_req) begin
          starve_cnt <= '0;
        end else if (core_req) begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end else begin
        starve_cnt <= '0;
      end

      // beat_cnt saturates at the limit: an unopposed host may stream far
      // past BURST_MAX, and a wrapped count would let it hold off a core
      // that starts requesting later. Saturated, such a host yields after
      // its next granted beat once the core is waiting.
      if (state == OWN_CORE) begin
        beat_cnt <= '0;
      end else if (host_gnt && beat_cnt != BURST_LAST) begin
        beat_cnt <= beat_cnt + 1'b1;
      end

      if (host_gnt && !host_we) begin
        host_rdata  <= mem_rdata;
        host_rvalid <= 1'b1;
      end else begin
        host_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter. A behavioural memory stands in for
// data_mem; a reference model tracks ownership with plain integer counts
// (consecutive denied cycles, beats granted in the current host tenure) and
// a shadow memory for expected data.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int AW        = 8;
  localparam int DW        = 8;
  localparam int STARVE    = 4;
  localparam int BURST_MAX = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          core_req, core_we, core_stall;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;
  logic          host_req, host_we, host_gnt, host_rvalid;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_we;
  arb_state_t    state;

  dmem_arbiter #(.AW(AW), .DW(DW), .STARVE(STARVE), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rdata(host_rdata),
    .host_rvalid(host_rvalid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .state(state)
  );

  // ---------------- data_mem stand-in ----------------
  logic          init_phase;
  logic [DW-1:0] tb_mem [256];
  always @(posedge clk) begin
    if (init_phase) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= DW'(i * 7 + 3);
    end else if (mem_we) begin
      tb_mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = tb_mem[mem_addr];

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  bit            m_host;      // model owner: 1 = host
  int            m_denied;    // consecutive cycles host denied while core requests
  int            m_beats;     // beats granted in current host tenure
  logic [DW-1:0] exp_mem [256];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] last_rd;

  bit            obs_gnt, obs_stall, obs_we;
  logic [DW-1:0] obs_crd;

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    reset = 1'b1;
    core_req = 1'b1; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    host_req = 1'b1; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (n) @(negedge clk);
    reset = 1'b0;
    m_host = 1'b0; m_denied = 0; m_beats = 0;
    exp_q.delete();
    last_rd = '0;
    #1;
    check("rst_state", 32'(state), 32'(OWN_CORE));
    check("rst_gnt", 32'(host_gnt), 0);
    check("rst_stall", 32'(core_stall), 0);
    check("rst_rvalid", 32'(host_rvalid), 0);
    check("rst_rdata", 32'(host_rdata), 0);
  endtask

  // One cycle: apply inputs, compare outputs to the model, advance the model.
  task automatic step(input bit creq, input bit cwe, input logic [AW-1:0] caddr,
                      input logic [DW-1:0] cwd, input bit hreq, input bit hwe,
                      input logic [AW-1:0] haddr, input logic [DW-1:0] hwd);
    bit            e_gnt, e_stall, e_we, e_rv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, e_rd;
    core_req = creq; core_we = cwe; core_addr = caddr; core_wdata = cwd;
    host_req = hreq; host_we = hwe; host_addr = haddr; host_wdata = hwd;
    #1;
    e_gnt   = m_host && hreq;
    e_stall = m_host && creq;
    e_we    = m_host ? (hreq && hwe) : (creq && cwe);
    e_addr  = m_host ? haddr : caddr;
    e_wd    = m_host ? hwd : cwd;
    if (exp_q.size() > 0) begin
      e_rv = 1'b1; e_rd = exp_q.pop_front(); last_rd = e_rd;
    end else begin
      e_rv = 1'b0; e_rd = last_rd;
    end
    check("state", 32'(state), 32'(m_host));
    check("host_gnt", 32'(host_gnt), 32'(e_gnt));
    check("core_stall", 32'(core_stall), 32'(e_stall));
    check("mem_we", 32'(mem_we), 32'(e_we));
    check("mem_addr", 32'(mem_addr), 32'(e_addr));
    check("mem_wdata", 32'(mem_wdata), 32'(e_wd));
    check("core_rdata", 32'(core_rdata), 32'(exp_mem[e_addr]));
    check("host_rvalid", 32'(host_rvalid), 32'(e_rv));
    check("host_rdata", 32'(host_rdata), 32'(e_rd));
    obs_gnt = host_gnt; obs_stall = core_stall; obs_we = mem_we; obs_crd = core_rdata;

    if (e_gnt && !hwe) exp_q.push_back(exp_mem[haddr]);
    if (e_we) exp_mem[e_addr] = e_wd;
    if (!m_host) begin
      if (hreq && (!creq || m_denied >= STARVE - 1)) begin
        m_host = 1'b1; m_beats = 0; m_denied = 0;
      end else if (hreq && creq) begin
        m_denied++;
      end else begin
        m_denied = 0;
      end
    end else if (!hreq) begin
      m_host = 1'b0;
    end else begin
      if (creq && m_beats >= BURST_MAX - 1) m_host = 1'b0;
      m_beats++;
    end
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int first_gnt, beat, run, first_run;
    for (int i = 0; i < 256; i++) exp_mem[i] = DW'(i * 7 + 3);
    reset = 1'b1; init_phase = 1'b1;
    core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    @(negedge clk);
    init_phase = 1'b0;
    do_reset(2);

    // starvation bound: both request from cycle 0
    first_gnt = -1;
    for (int c = 0; c < 8; c++) begin
      step(1'b1, 1'b0, AW'(c), '0, 1'b1, 1'b0, 8'h80, '0);
      if (obs_gnt && first_gnt < 0) begin
        first_gnt = c;
        check("starve_stall_at_gnt", 32'(obs_stall), 1);
      end
    end
    check("starve_first_gnt", 32'(first_gnt), STARVE);

    // burst limit: host writes 0x10.. to 0x00.. while core requests
    do_reset(1);
    beat = 0; run = 0; first_run = -1;
    for (int c = 0; c < 120 && beat < 16; c++) begin
      step(1'b1, 1'b0, 8'hF0, '0, 1'b1, 1'b1, AW'(beat), DW'(8'h10 + beat));
      if (obs_gnt) begin
        beat++; run++;
      end else if (run > 0 && first_run < 0) begin
        first_run = run;
      end
    end
    check("burst_len", 32'(first_run), BURST_MAX);
    check("burst_done", 32'(beat), 16);
    for (int i = 0; i < 16; i++) check("burst_mem", 32'(tb_mem[i]), 32'(8'h10 + i));

    // unopposed streaming: 12 host reads, core idle
    do_reset(1);
    beat = 0; run = 0; first_run = 0;
    for (int c = 0; c < 40 && beat < 12; c++) begin
      step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, AW'(8'h20 + beat), '0);
      if (obs_gnt) begin
        beat++; run++;
        if (run > first_run) first_run = run;
      end else begin
        run = 0;
      end
    end
    check("stream_run", 32'(first_run), 12);
    step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);   // collects last rvalid

    // handback bubble
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'h30, '0);    // host takes over
    step(1'b1, 1'b1, 8'h31, 8'h77, 1'b1, 1'b0, 8'h30, '0); // granted read
    step(1'b1, 1'b1, 8'h31, 8'h77, 1'b0, 1'b1, 8'h30, 8'h55);
    check("handback_stall", 32'(obs_stall), 1);
    check("handback_we", 32'(obs_we), 0);
    step(1'b1, 1'b1, 8'h31, 8'h77, 1'b0, 1'b0, '0, '0);
    check("handback_core_back", 32'(obs_stall), 0);

    // mid-burst reset
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 8'h40, 8'hAA);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 8'h40, 8'hAA);
    step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 8'h41, '0);
    do_reset(1);
    step(1'b1, 1'b0, 8'h40, '0, 1'b0, 1'b0, '0, '0);
    check("mid_rst_core_read", 32'(obs_crd), 32'h0000_00AA);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 99) < 60, $urandom_range(0, 1) == 1,
           AW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)),
           $urandom_range(0, 99) < 55, $urandom_range(0, 2) == 0,
           AW'($urandom_range(0, 255)), DW'($urandom_range(0, 255)));
    end

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule
